// File: rtl/alu_sequencer.sv
// alu_sequencer: execute-stage controller in front of the 16-bit logic unit.
// It accepts one operation over a valid/ready handshake and drives the logic
// unit for a single cycle. It captures the result and the status flags, then
// holds them for downstream until they are consumed. Transactions never
// overlap: IDLE -> EXEC -> DONE -> IDLE.
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             alu_passthrough,
    output logic             alu_add,
    output logic             alu_sub,
    output logic             alu_shr,
    output logic             alu_shl,
    output logic             alu_band,
    output logic             alu_bor,
    output logic             alu_bxor,
    output logic             alu_bnegate,
    output logic [WIDTH-1:0] alu_bus1,
    output logic [WIDTH-1:0] alu_bus2,
    input  logic [WIDTH-1:0] alu_bus3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SHR = 4'd3;
    localparam logic [3:0] OP_SHL = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd8;

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             neg_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             illegal_reg;
    logic             out_valid_reg;

    // sel bit k selects opcode k+1 (ADD..NOT); MOV and illegal codes select nothing
    logic [7:0]       sel_dec;
    logic [7:0]       sel_reg;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH-1:0] result_next;
    logic             carry_next;
    logic             ovf_next;
    logic             illegal_next;

    // Select decode of the incoming opcode, registered on accept so the
    // selects are high for exactly the EXEC cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sel_dec
            assign sel_dec[gi] = (in_op == 4'(gi + 1));
        end
    endgenerate

    assign in_ready        = (state_reg == IDLE) && !rst;
    assign alu_passthrough = 1'b0;
    assign alu_add         = sel_reg[0];
    assign alu_sub         = sel_reg[1];
    assign alu_shr         = sel_reg[2];
    assign alu_shl         = sel_reg[3];
    assign alu_band        = sel_reg[4];
    assign alu_bor         = sel_reg[5];
    assign alu_bxor        = sel_reg[6];
    assign alu_bnegate     = sel_reg[7];
    assign alu_bus1        = a_reg;
    assign alu_bus2        = b_reg;
    assign out_valid       = out_valid_reg;
    assign out_result      = result_reg;
    assign out_zero        = zero_reg;
    assign out_neg         = neg_reg;
    assign out_carry       = carry_reg;
    assign out_ovf         = ovf_reg;
    assign out_illegal     = illegal_reg;

    // Result selection and the carry/overflow flags the logic unit lacks.
    always_comb begin
        sum_ext      = {1'b0, a_reg} + {1'b0, b_reg};
        diff         = a_reg - b_reg;
        // Shifting by the full B through one extra bit position leaves the
        // last bit shifted out there; B of 0 or above 16 leaves it 0.
        shl_ext      = {1'b0, a_reg} << b_reg;
        shr_ext      = {a_reg, 1'b0} >> b_reg;
        illegal_next = (op_reg > OP_NOT);
        result_next  = '0;
        carry_next   = 1'b0;
        ovf_next     = 1'b0;
        if (op_reg == OP_MOV) begin
            result_next = a_reg;
        end else if (!illegal_next) begin
            result_next = alu_bus3;
        end
        case (op_reg)
            OP_ADD: begin
                carry_next = sum_ext[WIDTH];
                ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                             (sum_ext[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                carry_next = (a_reg < b_reg);
                ovf_next   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                             (diff[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SHR:  carry_next = shr_ext[0];
            OP_SHL:  carry_next = shl_ext[WIDTH];
            default: begin
                carry_next = 1'b0;
                ovf_next   = 1'b0;
            end
        endcase
    end

    // Sequencer FSM: latch operands, run one EXEC cycle, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sel_reg       <= '0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            neg_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg    <= in_op;
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        sel_reg   <= sel_dec;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    sel_reg       <= '0;
                    result_reg    <= result_next;
                    zero_reg      <= (result_next == '0);
                    neg_reg       <= result_next[WIDTH-1];
                    carry_reg     <= carry_next;
                    ovf_reg       <= ovf_next;
                    illegal_reg   <= illegal_next;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    sel_reg       <= '0;
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural
// model of the downstream logic unit.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        alu_passthrough, alu_add, alu_sub, alu_shr, alu_shl;
    logic        alu_band, alu_bor, alu_bxor, alu_bnegate;
    logic [15:0] alu_bus1, alu_bus2, alu_bus3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_zero, out_neg, out_carry, out_ovf, out_illegal;

    typedef struct {
        logic [15:0] res;
        logic        z, n, c, v, il;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic pt_seen = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .alu_passthrough(alu_passthrough), .alu_add(alu_add), .alu_sub(alu_sub),
        .alu_shr(alu_shr), .alu_shl(alu_shl), .alu_band(alu_band),
        .alu_bor(alu_bor), .alu_bxor(alu_bxor), .alu_bnegate(alu_bnegate),
        .alu_bus1(alu_bus1), .alu_bus2(alu_bus2), .alu_bus3(alu_bus3),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry),
        .out_ovf(out_ovf), .out_illegal(out_illegal)
    );

    // Behavioural logic unit: combinational result from the selects.
    always_comb begin
        alu_bus3 = 16'h0000;
        if (alu_add)     alu_bus3 = alu_bus1 + alu_bus2;
        if (alu_sub)     alu_bus3 = alu_bus1 - alu_bus2;
        if (alu_shr)     alu_bus3 = alu_bus1 >> alu_bus2;
        if (alu_shl)     alu_bus3 = alu_bus1 << alu_bus2;
        if (alu_band)    alu_bus3 = alu_bus1 & alu_bus2;
        if (alu_bor)     alu_bus3 = alu_bus1 | alu_bus2;
        if (alu_bxor)    alu_bus3 = alu_bus1 ^ alu_bus2;
        if (alu_bnegate) alu_bus3 = ~alu_bus1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [16:0] s;
        int          bi;
        e.res = 16'h0; e.c = 1'b0; e.v = 1'b0; e.il = 1'b0;
        bi = int'(b);
        case (op)
            4'd0: e.res = a;
            4'd1: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[15:0];
                e.c   = s[16];
                e.v   = (a[15] == b[15]) && (e.res[15] != a[15]);
            end
            4'd2: begin
                e.res = a - b;
                e.c   = (a < b);
                e.v   = (a[15] != b[15]) && (e.res[15] != a[15]);
            end
            4'd3: begin
                e.res = (bi >= 16) ? 16'h0 : (a >> bi);
                e.c   = (bi >= 1 && bi <= 16) ? a[bi-1] : 1'b0;
            end
            4'd4: begin
                e.res = (bi >= 16) ? 16'h0 : (a << bi);
                e.c   = (bi >= 1 && bi <= 16) ? a[16-bi] : 1'b0;
            end
            4'd5: e.res = a & b;
            4'd6: e.res = a | b;
            4'd7: e.res = a ^ b;
            4'd8: e.res = ~a;
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == 16'h0);
        e.n = e.res[15];
        return e;
    endfunction

    // Scoreboard: compare each consumed result against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (alu_passthrough) pt_seen = 1'b1;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                $display("out: result=0x%04h z=%0b n=%0b c=%0b v=%0b il=%0b",
                         out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal);
                chk("result", 32'(out_result), 32'(e.res));
                chk("zero", 32'(out_zero), 32'(e.z));
                chk("neg", 32'(out_neg), 32'(e.n));
                chk("carry", 32'(out_carry), 32'(e.c));
                chk("ovf", 32'(out_ovf), 32'(e.v));
                chk("illegal", 32'(out_illegal), 32'(e.il));
            end
        end
    end

    function automatic logic [7:0] sels();
        return {alu_bnegate, alu_bxor, alu_bor, alu_band, alu_shl, alu_shr, alu_sub, alu_add};
    endfunction

    // Present one operation and check the EXEC cycle. Returns one cycle after accept.
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit push);
        int          n = 0;
        logic [7:0]  exp_sel;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        $display("in: op=%0d a=0x%04h b=0x%04h", op, a, b);
        if (push) q.push_back(model(op, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_sel = (op >= 4'd1 && op <= 4'd8) ? (8'h01 << (op - 4'd1)) : 8'h00;
        chk("exec_sel", 32'(sels()), 32'(exp_sel));
        chk("exec_pt", 32'(alu_passthrough), 32'd0);
        chk("exec_bus1", 32'(alu_bus1), 32'(a));
        chk("exec_bus2", 32'(alu_bus2), 32'(b));
        chk("exec_out_valid", 32'(out_valid), 32'd0);
        chk("exec_in_ready", 32'(in_ready), 32'd0);
    endtask

    // Full transaction with out_ready held high.
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        send(op, a, b, 1'b1);
        @(posedge clk); #1;
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("done_sel", 32'(sels()), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [3:0]  rop;
        logic [15:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_a = 16'h0; in_b = 16'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_flags", 32'({out_zero, out_neg, out_carry, out_ovf, out_illegal}), 32'd0);
        chk("rst_sel", 32'(sels()), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed cases
        do_op(4'd1, 16'hFFFF, 16'h0001);
        do_op(4'd2, 16'h8000, 16'h0001);
        do_op(4'd2, 16'h0001, 16'h0002);
        do_op(4'd4, 16'h8001, 16'd1);
        do_op(4'd3, 16'h0003, 16'd20);
        do_op(4'd0, 16'h1234, 16'h5555);
        do_op(4'd12, 16'hABCD, 16'h0003);
        do_op(4'd1, 16'h7FFF, 16'h0001);
        do_op(4'd4, 16'h0001, 16'd16);
        do_op(4'd3, 16'h8000, 16'd16);
        do_op(4'd3, 16'h8421, 16'd0);
        do_op(4'd5, 16'hF0F0, 16'h3C3C);
        do_op(4'd6, 16'hF0F0, 16'h3C3C);
        do_op(4'd7, 16'hF0F0, 16'h3C3C);
        do_op(4'd8, 16'h00FF, 16'h1234);

        // Random operations
        for (int i = 0; i < 24; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = (rop == 4'd3 || rop == 4'd4) ? 16'($urandom_range(0, 18)) : 16'($urandom);
            do_op(rop, ra, rb);
        end

        // Backpressure: result holds, in_ready stays low, new request ignored
        out_ready = 1'b0;
        e = model(4'd1, 16'h7FFF, 16'h7FFF);
        send(4'd1, 16'h7FFF, 16'h7FFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                in_valid = 1'b1; in_op = 4'd2; in_a = 16'h0001; in_b = 16'h0001;
            end
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", 32'(out_result), 32'(e.res));
            chk("bp_ovf", 32'(out_ovf), 32'(e.v));
            chk("bp_neg", 32'(out_neg), 32'(e.n));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_no_accept", 32'(out_valid), 32'd0);
        chk("bp_queue_empty", 32'(q.size()), 32'd0);

        // Reset during EXEC abandons the operation
        send(4'd1, 16'h0002, 16'h0003, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_exec_out_valid", 32'(out_valid), 32'd0);
        chk("rst_exec_in_ready", 32'(in_ready), 32'd0);
        chk("rst_exec_sel", 32'(sels()), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_exec_ready_after", 32'(in_ready), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_exec_no_output", 32'(out_valid), 32'd0);
        end
        do_op(4'd2, 16'h0005, 16'h0003);

        @(posedge clk); #1;
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        chk("passthrough_never", 32'(pt_seen), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
